prog_loader: RTL

//   Serial boot loader for the Hack uC. Receives a framed program image on a UART

---
 rtl/prog_loader_pkg.sv | 30 +++
 rtl/prog_loader_uart_rx.sv | 87 ++++++++
 rtl/prog_loader.sv | 137 +++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the serial program loader.
package prog_loader_pkg;

  localparam int unsigned DW = 16;
  localparam int unsigned PW = 15;
  localparam int unsigned IW = PW + 1;

  typedef logic [7:0]    byte_t;
  typedef logic [DW-1:0] word_t;
  typedef logic [PW-1:0] paddr_t;

  localparam byte_t SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_HI,
    S_CNT_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CSUM
  } ldr_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/prog_loader_uart_rx.sv
// 8N1 UART receiver: synchronizes rx, samples mid-bit, flags bad stop bits.
module uart_rx
  import prog_loader_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 115_200
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  rx,
  output byte_t byte_data,
  output logic  byte_valid,
  output logic  frame_err
);

  localparam int unsigned BIT_CYC = CLK_HZ / BAUD;
  localparam int unsigned HALF    = BIT_CYC / 2;
  localparam int unsigned CW      = $clog2(BIT_CYC + 1);

  logic          rx_meta;
  logic          rx_s;
  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  byte_t         shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_s       <= rx_meta;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= RX_START;
        end
        // Re-check half a bit in so a glitch does not start a byte.
        RX_START: begin
          if (cnt == CW'(HALF - 1)) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (cnt == CW'(BIT_CYC - 1)) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (cnt == CW'(BIT_CYC - 1)) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rx_s) begin
              byte_data  <= shreg;
              byte_valid <= 1'b1;
            end else begin
              frame_err  <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Serial boot loader: parses a framed image from the UART and writes program RAM,
// holding the CPU in reset while a load is in progress.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 115_200,
  parameter int unsigned TO_CYC = 5_000_000,
  parameter byte_t       SYNC   = SYNC_BYTE
) (
  input  logic   clk50m,
  input  logic   rst_n,
  input  logic   rx,
  output paddr_t prog_addr,
  output word_t  prog_data,
  output logic   prog_we,
  output logic   cpu_rst_n,
  output logic   busy,
  output logic   done,
  output logic   err
);

  localparam int unsigned TW = $clog2(TO_CYC + 1);

  byte_t         byte_data;
  logic          byte_valid;
  logic          frame_err;

  ldr_state_t    state;
  byte_t         hi_byte;
  word_t         cnt;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_nxt;
  byte_t         sum;
  logic [TW-1:0] to_cnt;
  word_t         cnt_in;
  logic          timeout;

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
    .clk       (clk50m),
    .rst_n     (rst_n),
    .rx        (rx),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  assign cnt_in  = {hi_byte, byte_data};
  assign idx_nxt = idx + IW'(1);
  assign timeout = (to_cnt == TW'(TO_CYC - 1));

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      hi_byte   <= '0;
      cnt       <= '0;
      idx       <= '0;
      sum       <= '0;
      to_cnt    <= '0;
      prog_addr <= '0;
      prog_data <= '0;
      prog_we   <= 1'b0;
      cpu_rst_n <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      prog_we <= 1'b0;
      if (byte_valid || frame_err || state == S_IDLE) to_cnt <= '0;
      else                                            to_cnt <= to_cnt + TW'(1);

      // Any failure mid-frame leaves the CPU held: the image may be partial.
      if (state != S_IDLE && (frame_err || timeout)) begin
        state <= S_IDLE;
        busy  <= 1'b0;
        err   <= 1'b1;
      end else if (byte_valid) begin
        sum <= sum + byte_data;
        case (state)
          S_IDLE: begin
            if (byte_data == SYNC) begin
              state     <= S_CNT_HI;
              busy      <= 1'b1;
              cpu_rst_n <= 1'b0;
              done      <= 1'b0;
              err       <= 1'b0;
              idx       <= '0;
              sum       <= '0;
            end
          end
          S_CNT_HI: begin
            hi_byte <= byte_data;
            state   <= S_CNT_LO;
          end
          S_CNT_LO: begin
            cnt <= cnt_in;
            if (cnt_in == '0) begin
              state <= S_CSUM;
            end else if (cnt_in > DW'(2 ** PW)) begin
              state <= S_IDLE;
              busy  <= 1'b0;
              err   <= 1'b1;
            end else begin
              state <= S_DATA_HI;
            end
          end
          S_DATA_HI: begin
            hi_byte <= byte_data;
            state   <= S_DATA_LO;
          end
          S_DATA_LO: begin
            prog_we   <= 1'b1;
            prog_data <= cnt_in;
            prog_addr <= idx[PW-1:0];
            idx       <= idx_nxt;
            state     <= (DW'(idx_nxt) == cnt) ? S_CSUM : S_DATA_HI;
          end
          S_CSUM: begin
            state <= S_IDLE;
            busy  <= 1'b0;
            if (byte_data == sum) begin
              done      <= 1'b1;
              cpu_rst_n <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
